sh7034_ibus_master: RTL and testbench
=====================================

# sh7034_ibus_master

Internal-bus initiator for the SH7034 on-chip peripheral bus. Turns one front-end command (byte/word/long, read or write) into a single IBUS transaction: big-endian byte-lane selects, write-data lane replication, BUSY wait-state handling, read-data extraction with sign or zero extension, and bus-error detection. It drives the same IBUS request/strobe protocol that the on-chip register responders (UBC, timers, DMAC) answer, and sits between the CPU/debug access path and those responders.

## Interface
- TO_W, 8: width of the wait-state timeout counter.
- TIMEOUT, 255: number of BUSY-high CE_R edges after which the access aborts with an error.
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- CE_R  in  1  rising-phase clock enable; all state advances on CE_R only.
- CE_F  in  1  falling-phase enable; unused internally, kept for port uniformity.
- CMD_REQ  in  1  command request, sampled at CE_R while CMD_READY=1.
- CMD_ADDR  in  28  byte address.
- CMD_WDATA  in  32  write data, right-aligned (byte in [7:0], word in [15:0]).
- CMD_SIZE  in  2  0=byte, 1=word, 2=long; 3 is treated as long.
- CMD_WE  in  1  1=write, 0=read.
- CMD_SIGNED  in  1  sign-extend read data for byte/word.
- CMD_READY  out  1  high in IDLE.
- RSP_VALID  out  1  one-CLK completion pulse.
- RSP_RDATA  out  32  extended read data; 0 for writes and errors.
- RSP_ERR  out  1  qualifies RSP_VALID: misaligned, no responder, or timeout.
- IBUS_A  out  28  address.
- IBUS_DO  out  32  write data to responder.
- IBUS_DI  in  32  read data from responder.
- IBUS_BA  out  4  byte enables; BA[3] = bits 31:24 = address offset 0.
- IBUS_WE  out  1  write strobe.
- IBUS_REQ  out  1  access request.
- IBUS_BUSY  in  1  responder wait.
- IBUS_ACT  in  1  OR of responder select lines.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: CMD_READY=1. At a CE_R edge with CMD_REQ=1, latch the command and check alignment.
  - Misaligned means a word with A[0]=1, or a long with A[1:0]≠0. A misaligned command goes to RESP with the error flagged and issues no bus cycle.
  - An aligned command goes to ACCESS and registers IBUS_A, IBUS_BA, IBUS_DO and IBUS_WE, with IBUS_REQ=1.
- Byte enables:
  - Byte: 4'b1000 >> A[1:0].
  - Word: A[1]=0 gives 4'b1100; A[1]=1 gives 4'b0011.
  - Long: 4'b1111.
- Write data: a byte is replicated ×4 across the lanes; a word is replicated ×2; a long is passed through.
- ACCESS, at each CE_R edge:
  - If IBUS_BUSY=0, the access completes. Capture IBUS_DI and IBUS_ACT, then go to RESP.
  - Else increment the timeout counter. When the counter reaches TIMEOUT, abort to RESP with the error flagged.
- RESP: lasts one CLK cycle, with RSP_VALID=1. Then go to IDLE and clear the counter.
- RSP_ERR=1 if the access was misaligned, timed out, or IBUS_ACT was 0 at completion.
- Read extraction (ERR=0 and WE=0):
  - Byte: select the lane from A[1:0] (offset 0 = DI[31:24]).
  - Word: A[1]=0 selects DI[31:16]; A[1]=1 selects DI[15:0].
  - Extension: zero-extend, or sign-extend when CMD_SIGNED=1.
- IBUS_REQ, IBUS_WE and IBUS_BA are 0 outside ACCESS. IBUS_A and IBUS_DO hold their last value.
- CMD_REQ is ignored outside IDLE. A new command is accepted no earlier than the first CE_R edge after RSP_VALID.

## Timing
- Reset values:
  - State IDLE, so CMD_READY=1.
  - RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0.
  - IBUS_A=0, IBUS_DO=0, IBUS_BA=0, IBUS_WE=0, IBUS_REQ=0.
  - Counter=0.
- RST asserted mid-access drops IBUS_REQ immediately (asynchronously). No response is produced.
- Command accepted at CE_R edge N: IBUS_REQ is high from edge N. The responder writes at edge N+1 and latches read data at the CE_F between N and N+1.
- Zero-wait completion at edge N+1. RSP_VALID is high in the CLK cycle after N+1. IBUS_REQ is low from edge N+1.
- Each BUSY-high CE_R edge adds one CE_R period.
- Timeout: the abort edge is edge N+TIMEOUT. The counter counts BUSY-high edges only.
- If BUSY falls on the same edge the counter would reach TIMEOUT, completion wins and ERR=0.
- Misaligned command accepted at edge N: RSP_VALID is high in the next CLK cycle, with no IBUS_REQ.
- With CE_R held low, all state freezes except the one-cycle RSP to IDLE transition.

## Test plan
- Long write 0xDEADBEEF to 0x5FFFF90, responder ACT=1, BUSY=0 -> IBUS_BA=1111 and IBUS_REQ high for one CE_R period; RSP_VALID with ERR=0, RDATA=0.
- Byte read, A[1:0]=2, IBUS_DI=0x00008000, SIGNED=1 -> BA=0010; RDATA=0xFFFFFF80. Same read with SIGNED=0 -> RDATA=0x00000080.
- Word write 0x1234 at A[1]=1 -> IBUS_DO=0x12341234, BA=0011. Word read at A=0x...1 -> no IBUS_REQ, RSP_ERR=1.
- Read with BUSY held high for 3 CE_R edges, DI=0xCAFEF00D -> RSP_VALID 4 CE_R periods after accept, RDATA=0xCAFEF00D. BUSY stuck high with TIMEOUT=4 -> ERR=1 at the 4th edge, REQ drops.
- Read of an unmapped address (ACT=0, BUSY=0) -> ERR=1, RDATA=0. CMD_REQ held high throughout -> exactly one access per RSP_VALID.
- Assert RST while in ACCESS -> all IBUS outputs 0 immediately, no RSP_VALID, CMD_READY=1 after release.

Source files
------------

// File: rtl/sh7034_ibus_master.sv
// sh7034_ibus_master
//
// Internal-bus initiator. Takes one front-end command (byte/word/long, read
// or write) and runs it as a single IBUS transaction towards the on-chip
// register responders (UBC, timers, DMAC).
//
// Handshakes (all state advances only on clock edges with CE_R=1, except the
// one-cycle RESP->IDLE step):
//   Command side : CMD_READY is high in IDLE; a command transfers on a CE_R
//                  edge where CMD_REQ=1 and CMD_READY=1. CMD_REQ is ignored
//                  otherwise. RSP_VALID is a single CLK pulse, one per
//                  accepted command, with RSP_ERR/RSP_RDATA qualified by it.
//   Bus side     : IBUS_REQ is high for the whole access; the responder holds
//                  it open with IBUS_BUSY=1, and the access completes on the
//                  first CE_R edge that sees IBUS_BUSY=0.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   CE_R, CE_F          rising/falling phase enables (CE_F unused here)
//   CMD_*               front-end command; CMD_READY back-pressure
//   RSP_*               completion pulse, error flag, extended read data
//   IBUS_A/DO/BA/WE/REQ bus outputs; IBUS_DI/BUSY/ACT responder inputs
//
// Parameters:
//   TO_W     width of the wait-state counter
//   TIMEOUT  BUSY-high CE_R edges after which the access aborts with error
module sh7034_ibus_master #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        CMD_REQ,
  input  logic [27:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  input  logic [1:0]  CMD_SIZE,
  input  logic        CMD_WE,
  input  logic        CMD_SIGNED,
  output logic        CMD_READY,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [27:0] IBUS_A,
  output logic [31:0] IBUS_DO,
  input  logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [27:0]       a_q, a_d;
  logic [31:0]       do_q, do_d;
  logic [3:0]        ba_q, ba_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;   // normalised: 0 byte, 1 word, 2 long
  logic              sgn_q, sgn_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              unused_ce_f;
  assign unused_ce_f = CE_F;

  // Decode of the incoming command.
  logic              cmd_long, cmd_word, cmd_misaligned;
  logic [1:0]        cmd_size_n;
  logic [3:0]        cmd_ba;
  logic [31:0]       cmd_do;

  always_comb begin
    cmd_long       = CMD_SIZE[1];                 // size 3 folds into long
    cmd_word       = (CMD_SIZE == 2'd1);
    cmd_misaligned = (cmd_word & CMD_ADDR[0]) | (cmd_long & (|CMD_ADDR[1:0]));
    cmd_size_n     = cmd_long ? 2'd2 : CMD_SIZE;

    cmd_ba = 4'b1111;
    cmd_do = CMD_WDATA;
    if (cmd_long) begin
      cmd_ba = 4'b1111;
      cmd_do = CMD_WDATA;
    end else if (cmd_word) begin
      cmd_ba = CMD_ADDR[1] ? 4'b0011 : 4'b1100;
      cmd_do = {CMD_WDATA[15:0], CMD_WDATA[15:0]};
    end else begin
      cmd_ba = 4'b1000 >> CMD_ADDR[1:0];
      cmd_do = {4{CMD_WDATA[7:0]}};
    end
  end

  // Read-data extraction, big-endian lanes: address offset 0 is DI[31:24].
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    rd_byte = IBUS_DI[31:24];
    case (a_q[1:0])
      2'd0:    rd_byte = IBUS_DI[31:24];
      2'd1:    rd_byte = IBUS_DI[23:16];
      2'd2:    rd_byte = IBUS_DI[15:8];
      default: rd_byte = IBUS_DI[7:0];
    endcase
    rd_half = a_q[1] ? IBUS_DI[15:0] : IBUS_DI[31:16];

    rd_ext = IBUS_DI;
    if (size_q == 2'd0)
      rd_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
    else if (size_q == 2'd1)
      rd_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
  end

  logic [TO_W-1:0] cnt_inc;
  assign cnt_inc = cnt_q + TO_W'(1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    do_d    = do_q;
    ba_d    = ba_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (CE_R && CMD_REQ) begin
          if (cmd_misaligned) begin
            // No bus cycle; bus-facing registers keep their previous values.
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = S_RESP;
          end else begin
            a_d     = CMD_ADDR;
            do_d    = cmd_do;
            ba_d    = cmd_ba;
            we_d    = CMD_WE;
            size_d  = cmd_size_n;
            sgn_d   = CMD_SIGNED;
            cnt_d   = '0;
            state_d = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        if (CE_R) begin
          if (!IBUS_BUSY) begin
            // Completion takes priority over a timeout on the same edge.
            err_d   = !IBUS_ACT;
            rdata_d = (IBUS_ACT && !we_q) ? rd_ext : 32'd0;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == TO_W'(TIMEOUT)) begin
              err_d   = 1'b1;
              rdata_d = 32'd0;
              state_d = S_RESP;
            end
          end
        end
      end

      S_RESP: begin
        // Unconditional: the response pulse is exactly one CLK long.
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      do_q    <= '0;
      ba_q    <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      do_q    <= do_d;
      ba_q    <= ba_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes are decoded from the state register so an asynchronous reset
  // drops them immediately.
  logic in_access, in_resp;
  assign in_access = (state_q == S_ACCESS);
  assign in_resp   = (state_q == S_RESP);

  assign CMD_READY = (state_q == S_IDLE);
  assign RSP_VALID = in_resp;
  assign RSP_ERR   = in_resp & err_q;
  assign RSP_RDATA = in_resp ? rdata_q : 32'd0;
  assign IBUS_A    = a_q;
  assign IBUS_DO   = do_q;
  assign IBUS_BA   = in_access ? ba_q : 4'd0;
  assign IBUS_WE   = in_access & we_q;
  assign IBUS_REQ  = in_access;

endmodule

// File: tb/tb_sh7034_ibus_master.sv
module tb_sh7034_ibus_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_phase;
  logic        ce_en;
  logic        ce_r, ce_f;
  logic        cmd_req;
  logic [27:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [1:0]  cmd_size;
  logic        cmd_we, cmd_signed;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [27:0] ibus_a;
  logic [31:0] ibus_do, ibus_di;
  logic [3:0]  ibus_ba;
  logic        ibus_we, ibus_req, ibus_busy, ibus_act;

  int checks = 0;
  int errors = 0;

  int rsp_cnt = 0;
  int acc_cnt = 0;
  int dbl_cnt = 0;
  logic req_prev = 1'b0;
  logic rv_prev  = 1'b0;

  sh7034_ibus_master #(.TO_W(8), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst), .CE_R(ce_r), .CE_F(ce_f),
    .CMD_REQ(cmd_req), .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
    .CMD_SIZE(cmd_size), .CMD_WE(cmd_we), .CMD_SIGNED(cmd_signed),
    .CMD_READY(cmd_ready), .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
    .RSP_ERR(rsp_err), .IBUS_A(ibus_a), .IBUS_DO(ibus_do), .IBUS_DI(ibus_di),
    .IBUS_BA(ibus_ba), .IBUS_WE(ibus_we), .IBUS_REQ(ibus_req),
    .IBUS_BUSY(ibus_busy), .IBUS_ACT(ibus_act)
  );

  // ---------------- clock / enables ----------------
  always #5 clk = ~clk;

  // CE_R on every other rising edge; stable between edges.
  always @(posedge clk or posedge rst) begin
    if (rst) ce_phase <= 1'b1;
    else     ce_phase <= ~ce_phase;
  end
  assign ce_r = ce_phase & ce_en;
  assign ce_f = ~ce_phase;

  // Bus activity monitor.
  always @(posedge clk) begin
    req_prev <= ibus_req;
    rv_prev  <= rsp_valid;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (ibus_req && !req_prev) acc_cnt <= acc_cnt + 1;
    if (rsp_valid && rv_prev) dbl_cnt <= dbl_cnt + 1;
  end

  // ---------------- reference model ----------------
  function automatic bit f_mis(input logic [27:0] a, input logic [1:0] s);
    int off;
    off = int'(a[1:0]);
    if (s == 2'd1) return (off % 2) != 0;
    if (s >= 2'd2) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] f_ba(input logic [27:0] a, input logic [1:0] s);
    int off;
    off = int'(a[1:0]);
    if (s == 2'd0) return 4'(1 << (3 - off));
    if (s == 2'd1) return (off < 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_do(input logic [31:0] w, input logic [1:0] s);
    if (s == 2'd0) return {24'd0, w[7:0]} * 32'h0101_0101;
    if (s == 2'd1) return {16'd0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] f_rd(input logic [31:0] di, input logic [27:0] a,
                                       input logic [1:0] s, input bit sg);
    int off, bits;
    logic [31:0] v;
    off = int'(a[1:0]);
    if (s >= 2'd2) return di;
    if (s == 2'd0) begin
      v = (di >> (8 * (3 - off))) & 32'hFF;
      bits = 8;
    end else begin
      v = (di >> (16 * (1 - off / 2))) & 32'hFFFF;
      bits = 16;
    end
    if (sg && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Raise CMD_REQ and return #1 after the edge that accepted the command.
  task automatic issue(input string name, output bit ok);
    int t;
    ok = 1'b1;
    @(negedge clk);
    cmd_req = 1'b1;
    t = 0;
    while (!(ce_r && cmd_ready)) begin
      @(negedge clk);
      t++;
      if (t > 20) begin
        checks++; errors++;
        $display("FAIL %s accept: cmd_ready=%b after %0d cycles, want 1", name, cmd_ready, t);
        cmd_req = 1'b0;
        ok = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    cmd_req = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic [27:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit we, input bit sg,
                         input int busy_n, input bit act, input logic [31:0] di);
    bit ok, mis, edge_hit, exp_err;
    int k, t, end_k;
    logic [31:0] exp_rd;
    cmd_addr = a; cmd_wdata = wd; cmd_size = sz; cmd_we = we; cmd_signed = sg;
    ibus_busy = (busy_n > 0); ibus_act = act; ibus_di = di;
    mis = f_mis(a, sz);
    end_k = 0;
    if (mis || busy_n >= TO) begin
      exp_err = 1'b1; exp_rd = 32'd0; end_k = TO;
    end else begin
      end_k = busy_n + 1;
      exp_err = !act;
      exp_rd = (act && !we) ? f_rd(di, a, sz, sg) : 32'd0;
    end
    issue(name, ok);
    if (!ok) return;
    if (mis) begin
      checks++;
      if (ibus_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
        errors++;
        $display("FAIL %s misaligned: req=%b valid=%b err=%b rdata=%h, want req=0 valid=1 err=1 rdata=0",
                 name, ibus_req, rsp_valid, rsp_err, rsp_rdata);
      end
    end else begin
      checks++;
      if (ibus_req !== 1'b1 || ibus_we !== we || ibus_ba !== f_ba(a, sz)) begin
        errors++;
        $display("FAIL %s strobes: req=%b we=%b ba=%b, want req=1 we=%b ba=%b",
                 name, ibus_req, ibus_we, ibus_ba, we, f_ba(a, sz));
      end
      checks++;
      if (ibus_a !== a || ibus_do !== f_do(wd, sz)) begin
        errors++;
        $display("FAIL %s addr/data: a=%h do=%h, want a=%h do=%h", name, ibus_a, ibus_do, a, f_do(wd, sz));
      end
      k = 0; t = 0;
      while (k < end_k) begin
        @(negedge clk);
        edge_hit = ce_r;
        if (edge_hit) begin
          k++;
          ibus_busy = (k <= busy_n);
        end
        @(posedge clk); #1;
        t++;
        if (edge_hit && k == end_k) begin
          checks++;
          if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rd || ibus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s response: valid=%b err=%b rdata=%h req=%b, want valid=1 err=%b rdata=%h req=0",
                     name, rsp_valid, rsp_err, rsp_rdata, ibus_req, exp_err, exp_rd);
          end
        end else begin
          checks++;
          if (rsp_valid !== 1'b0 || ibus_req !== 1'b1) begin
            errors++;
            $display("FAIL %s wait edge %0d: valid=%b req=%b, want valid=0 req=1",
                     name, k, rsp_valid, ibus_req);
          end
        end
        if (t > 400) begin
          checks++; errors++;
          $display("FAIL %s completion timeout: k=%0d, want %0d", name, k, end_k);
          break;
        end
      end
    end
    ibus_busy = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || ibus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s after response: valid=%b req=%b, want 0 0", name, rsp_valid, ibus_req);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset rsp: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 0",
               cmd_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    checks++;
    if (ibus_a !== 28'd0 || ibus_do !== 32'd0 || ibus_ba !== 4'd0 || ibus_we !== 1'b0 || ibus_req !== 1'b0) begin
      errors++;
      $display("FAIL reset ibus: a=%h do=%h ba=%b we=%b req=%b, want all 0",
               ibus_a, ibus_do, ibus_ba, ibus_we, ibus_req);
    end
  endtask

  task automatic test_directed();
    run_txn("long_write",   28'h5FFFF90, 32'hDEADBEEF, 2'd2, 1'b1, 1'b0, 0, 1'b1, 32'h0);
    run_txn("byte_rd_s",    28'h0000102, 32'h0,        2'd0, 1'b0, 1'b1, 0, 1'b1, 32'h0000_8000);
    run_txn("byte_rd_u",    28'h0000102, 32'h0,        2'd0, 1'b0, 1'b0, 0, 1'b1, 32'h0000_8000);
    run_txn("word_write",   28'h0000202, 32'h0000_1234, 2'd1, 1'b1, 1'b0, 0, 1'b1, 32'h0);
    run_txn("word_mis",     28'h0000301, 32'h0,        2'd1, 1'b0, 1'b0, 0, 1'b1, 32'h0);
    run_txn("long_mis",     28'h0000302, 32'h0,        2'd3, 1'b0, 1'b0, 0, 1'b1, 32'h0);
    run_txn("busy3_read",   28'h0000400, 32'h0,        2'd2, 1'b0, 1'b0, 3, 1'b1, 32'hCAFE_F00D);
    run_txn("busy_stuck",   28'h0000404, 32'h0,        2'd2, 1'b0, 1'b0, 50, 1'b1, 32'h1111_2222);
    run_txn("unmapped",     28'h7000000, 32'h0,        2'd2, 1'b0, 1'b0, 0, 1'b0, 32'h5555_AAAA);
    run_txn("word_rd_s_hi", 28'h0000500, 32'h0,        2'd1, 1'b0, 1'b1, 1, 1'b1, 32'h8001_7FFF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn("random", 28'($urandom), $urandom, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 5)), ($urandom_range(0, 4) != 0), $urandom);
    end
  endtask

  task automatic test_freeze();
    bit ok;
    int t;
    cmd_addr = 28'h0000600; cmd_size = 2'd2; cmd_we = 1'b0; cmd_signed = 1'b0;
    ibus_busy = 1'b0; ibus_act = 1'b1; ibus_di = 32'h0BAD_F00D;
    issue("freeze", ok);
    if (!ok) return;
    @(negedge clk); ce_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ibus_req !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL freeze hold: req=%b valid=%b, want 1 0", ibus_req, rsp_valid);
      end
    end
    @(negedge clk); ce_en = 1'b1;
    t = 0;
    while (rsp_valid !== 1'b1 && t < 10) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL freeze resume: valid=%b err=%b rdata=%h, want 1 0 0badf00d", rsp_valid, rsp_err, rsp_rdata);
    end
    // RESP -> IDLE must still happen with CE_R held low.
    cmd_addr = 28'h0000601; cmd_size = 2'd1;
    issue("freeze_resp", ok);
    if (!ok) return;
    @(negedge clk); ce_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL freeze_resp: ready=%b valid=%b, want 1 0", cmd_ready, rsp_valid);
    end
    @(negedge clk); ce_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int acc0, rsp0;
    acc0 = acc_cnt; rsp0 = rsp_cnt;
    @(negedge clk);
    cmd_addr = 28'h0000700; cmd_size = 2'd2; cmd_we = 1'b1; cmd_wdata = $urandom;
    ibus_busy = 1'b0; ibus_act = 1'b1;
    cmd_req = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk); cmd_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if ((acc_cnt - acc0) != (rsp_cnt - rsp0) || (acc_cnt - acc0) < 8) begin
      errors++;
      $display("FAIL back_to_back: accesses=%0d responses=%0d, want equal and >=8",
               acc_cnt - acc0, rsp_cnt - rsp0);
    end
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    int rsp0;
    cmd_addr = 28'h0000800; cmd_size = 2'd2; cmd_we = 1'b1; cmd_wdata = 32'h1234_5678;
    ibus_busy = 1'b1; ibus_act = 1'b1;
    issue("rst_mid", ok);
    if (!ok) return;
    checks++;
    if (ibus_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid pre: req=%b, want 1", ibus_req);
    end
    rsp0 = rsp_cnt;
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (ibus_req !== 1'b0 || ibus_we !== 1'b0 || ibus_ba !== 4'd0 || ibus_a !== 28'd0 ||
        ibus_do !== 32'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid async: req=%b we=%b ba=%b a=%h do=%h ready=%b, want 0 0 0 0 0 1",
               ibus_req, ibus_we, ibus_ba, ibus_a, ibus_do, cmd_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; ibus_busy = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (rsp_cnt != rsp0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid after: responses=%0d ready=%b, want 0 1", rsp_cnt - rsp0, cmd_ready);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; ce_en = 1'b1;
    cmd_req = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_size = '0; cmd_we = 1'b0; cmd_signed = 1'b0;
    ibus_di = '0; ibus_busy = 1'b0; ibus_act = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_directed();
    test_random();
    test_freeze();
    test_back_to_back();
    test_reset_mid_access();
    checks++;
    if (dbl_cnt != 0) begin
      errors++;
      $display("FAIL rsp_pulse_width: multi-cycle pulses=%0d, want 0", dbl_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
